uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Shares one UART transmitter and its baud generator between NUM_REQ byte requesters, using round-robin arbitration.
- Per granted request, programs the baud generator rate select, holding the generator in reset while the rate settles if the rate changes.
- Then pulses the transmitter start and waits for the frame to complete.
- Sits between client logic and the baud_gen/TX datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SETTLE_CYCLES, 4, clk cycles baud_rst_n is held low after a rate change (>=1)
- TIMEOUT_CYCLES, 65535, watchdog limit; only used with the optional feature

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request level; held until granted
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- req_sel  input  2*NUM_REQ  baud select for requester i at [2i+1:2i]; 00=9600, 01=19200, 10=38400, 11=57600
- grant  output  NUM_REQ  one-hot, one-cycle pulse; request accepted and data captured
- baud_sel  output  2  rate select to baud generator
- baud_rst_n  output  1  active-low reset to baud generator
- tx_start  output  1  one-cycle start pulse to transmitter
- tx_data  output  8  byte to transmitter, stable from grant until return to IDLE
- tx_busy  input  1  transmitter busy level
- busy  output  1  high in any state except IDLE
- active_id  output  $clog2(NUM_REQ)  index of current owner
- timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values:
  - state IDLE; grant 0, tx_start 0, busy 0, timeout_err 0.
  - tx_data 0, active_id 0, baud_sel 00.
  - baud_rst_n 0 while reset is asserted; 1 from the first clk edge after release.
  - RR pointer last = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation aborts everything immediately. No grant is repeated; requesters re-request.
- States: IDLE, CFG, START, WAIT_BUSY, WAIT_DONE.
- IDLE, with |req:
  - Winner = first asserted index searching last+1, last+2, ... modulo NUM_REQ.
  - Registered on the same edge: grant[winner]=1 for one cycle, active_id=winner, tx_data=req_data[winner], last=winner.
  - If req_sel[winner] != baud_sel: baud_sel<=req_sel[winner], baud_rst_n<=0, go to CFG.
  - Otherwise go to START.
- CFG: counts SETTLE_CYCLES cycles with baud_rst_n=0, then drives baud_rst_n<=1 and goes to START.
- START: tx_start=1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - The next arbitration can occur in the IDLE cycle.
  - Minimum 1 idle cycle between grants.
- Latency:
  - req to grant: 1 cycle.
  - grant to tx_start: 1 cycle with no rate change; SETTLE_CYCLES+1 with a rate change.
- Requests arriving while busy are held pending and are not dropped.
- A requester deasserting req before grant is simply skipped.
- Simultaneous requests: the RR order above decides.
- A requester that re-requests immediately is ordered last among the active requesters.
- baud_sel changes only on the IDLE-exit edge and never while baud_rst_n=1 mid-frame.
- The pointer wraps NUM_REQ-1 -> 0.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES, it pulses timeout_err for 1 cycle, drives baud_rst_n<=0 for SETTLE_CYCLES cycles (a resync via CFG-like hold), then returns to IDLE.
- When undefined: no counter is built, timeout_err is tied 0, and the WAIT states wait indefinitely.

Test Plan:
- Reset, then req=0001, req_sel0=00, data 0xA5 -> grant=0001 the next cycle; tx_start 1 cycle later (no CFG); tx_data=0xA5; TX model busy 10 cycles -> busy falls 1 cycle after tx_busy=0.
- req=1111 held, all req_sel=00 -> grants in order 0001, 0010, 0100, 1000, 0001; each grant is exactly one cycle.
- Requester 2 with req_sel=11 while baud_sel=00 -> baud_sel=11 on the grant edge; baud_rst_n low exactly 4 cycles; tx_start on the following cycle.
- Assert reset during WAIT_DONE -> all outputs return to reset values asynchronously, baud_rst_n=0; after release, pending requester 0 is re-granted.
- Requester 1 drops req the cycle before arbitration while requester 3 holds -> grant=1000; requester 1 is never granted.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, tx_busy held 0 -> timeout_err pulses after 20 cycles, baud_rst_n low 4 cycles, FSM returns to IDLE.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter and baud generator between NUM_REQ requesters.
// Optional watchdog abort is enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
   parameter int NUM_REQ        = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [2*NUM_REQ-1:0]       req_sel,
   output logic [NUM_REQ-1:0]         grant,
   output logic [1:0]                 baud_sel,
   output logic                       baud_rst_n,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] active_id,
   output logic                       timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int SCW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, CFG, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t         r_state;
   logic [IDW-1:0] r_last;
   logic [SCW-1:0] r_cnt;
   logic           r_resync;

   logic           w_found;
   logic [IDW-1:0] w_win;
   logic [IDW-1:0] w_idx;
   logic [1:0]     w_sel;
   logic [7:0]     w_data;
   logic           w_to;

   // Search starts just after the previous owner, so it ends up last in line.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = IDW'((int'(r_last) + k) % NUM_REQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_sel  = 2'b00;
      w_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == IDW'(i)) begin
            w_sel  = req_sel[2*i +: 2];
            w_data = req_data[8*i +: 8];
         end
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TOW-1:0] r_wdog;
   logic           r_timeout_err;
   logic           w_wait;

   assign w_wait      = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
   assign w_to        = w_wait && (r_wdog == TOW'(TIMEOUT_CYCLES - 1));
   assign timeout_err = r_timeout_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_to;
         if (r_state == START)
            r_wdog <= '0;
         else if (w_wait && !w_to)
            r_wdog <= r_wdog + 1'b1;
      end
   end
`else
   assign w_to        = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last     <= IDW'(NUM_REQ - 1);
         r_cnt      <= '0;
         r_resync   <= 1'b0;
         grant      <= '0;
         baud_sel   <= 2'b00;
         baud_rst_n <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         busy       <= 1'b0;
         active_id  <= '0;
      end else begin
         grant    <= '0;
         tx_start <= 1'b0;
         case (r_state)
            IDLE: begin
               baud_rst_n <= 1'b1;
               if (w_found) begin
                  grant     <= NUM_REQ'(1) << w_win;
                  active_id <= w_win;
                  tx_data   <= w_data;
                  r_last    <= w_win;
                  busy      <= 1'b1;
                  r_cnt     <= '0;
                  if (w_sel != baud_sel) begin
                     baud_sel   <= w_sel;
                     baud_rst_n <= 1'b0;
                     r_state    <= CFG;
                  end else begin
                     r_state <= START;
                  end
               end
            end
            // Shared by rate change and watchdog resync; r_resync picks the exit.
            CFG: begin
               if (r_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                  baud_rst_n <= 1'b1;
                  r_resync   <= 1'b0;
                  if (r_resync) begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     r_state <= START;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            START: begin
               tx_start <= 1'b1;
               r_state  <= WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
               if (w_to) begin
                  baud_rst_n <= 1'b0;
                  r_cnt      <= '0;
                  r_resync   <= 1'b1;
                  r_state    <= CFG;
               end else if (r_state == WAIT_BUSY) begin
                  if (tx_busy) r_state <= WAIT_DONE;
               end else if (!tx_busy) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: a transaction-level model predicts winner, data, latency and settle time.
// The timeout scenario is exercised when UART_TX_SCHED_TIMEOUT_EN is defined.
module tb_uart_tx_sched;

   localparam int N       = 4;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 20;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [2*N-1:0] req_sel = '0;
   logic [N-1:0]   grant;
   logic [1:0]     baud_sel;
   logic           baud_rst_n;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy = 1'b0;
   logic           busy;
   logic [1:0]     active_id;
   logic           timeout_err;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int         m_last = N - 1;
   logic [1:0] m_rate = 2'b00;

   // per-transaction stimulus knobs
   logic [N-1:0] mid_add  = '0;
   logic [N-1:0] end_drop = '0;
   int           tx_dly   = 0;
   int           tx_len   = 4;
   bit           rs       = 1'b1;

   uart_tx_sched #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_sel(req_sel),
      .grant(grant), .baud_sel(baud_sel), .baud_rst_n(baud_rst_n), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy), .active_id(active_id),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] s);
      req[i]             = 1'b1;
      req_data[8*i +: 8] = d;
      req_sel[2*i +: 2]  = s;
   endtask

   task automatic new_req(input int i);
      logic [1:0] s;
      s = 2'b00;
      if (rs) s = ($urandom_range(0, 1) == 1) ? m_rate : 2'($urandom_range(0, 3));
      set_req(i, 8'($urandom), s);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_tx_start"}, 32'(tx_start), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_baud_rst_n"}, 32'(baud_rst_n), 0);
      chk({tag, "_tx_data"}, 32'(tx_data), 0);
      chk({tag, "_active_id"}, 32'(active_id), 0);
      chk({tag, "_baud_sel"}, 32'(baud_sel), 0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
   endtask

   // One full transaction from arbitration to return to idle; abort=1 resets in WAIT_DONE.
   task automatic serve(input bit abort);
      int         w, lat, lows;
      logic [7:0] d;
      logic [1:0] s;
      bit         rc;
      w  = rr_pick(req, m_last);
      d  = req_data[8*w +: 8];
      s  = req_sel[2*w +: 2];
      rc = (s != m_rate);
      step();
      chk("grant", 32'(grant), 32'(4'b0001 << w));
      chk("active_id", 32'(active_id), 32'(w));
      chk("tx_data", 32'(tx_data), 32'(d));
      chk("baud_sel", 32'(baud_sel), 32'(s));
      chk("busy_on", 32'(busy), 1);
      m_last = w;
      m_rate = s;
      req[w] = 1'b0;
      for (int i = 0; i < N; i++) if (mid_add[i] && !req[i]) new_req(i);
      mid_add = '0;
      lows = (baud_rst_n == 1'b0) ? 1 : 0;
      step();
      lat = 1;
      chk("grant_pulse", 32'(grant), 0);
      while (tx_start !== 1'b1 && lat < SETTLE + 6) begin
         if (baud_rst_n == 1'b0) lows++;
         step();
         lat++;
      end
      chk("start_lat", 32'(lat), rc ? 32'(SETTLE + 1) : 1);
      chk("rst_low", 32'(lows), rc ? 32'(SETTLE) : 0);
      chk("baud_rst_n_run", 32'(baud_rst_n), 1);
      if (tx_dly == 0) tx_busy = 1'b1;
      step();
      chk("start_pulse", 32'(tx_start), 0);
      chk("busy_mid", 32'(busy), 1);
      if (tx_dly > 0) begin
         repeat (tx_dly - 1) step();
         tx_busy = 1'b1;
      end
      if (abort) begin
         step();
         step();
         #2 reset = 1'b1;
         #1 chk_reset_vals("async_rst");
         tx_busy = 1'b0;
         return;
      end
      repeat (tx_len) step();
      chk("tx_data_hold", 32'(tx_data), 32'(d));
      tx_busy = 1'b0;
      step();
      chk("busy_fall", 32'(busy), 0);
      chk("no_timeout", 32'(timeout_err), 0);
      for (int i = 0; i < N; i++) if (end_drop[i]) req[i] = 1'b0;
      end_drop = '0;
   endtask

   initial begin
      repeat (3) step();
      chk_reset_vals("reset");
      @(negedge clk) reset = 1'b0;
      step();
      chk("rst_n_release", 32'(baud_rst_n), 1);
      chk("idle_busy", 32'(busy), 0);

      // single requester, no rate change
      set_req(0, 8'hA5, 2'b00);
      tx_dly = 0; tx_len = 10;
      serve(1'b0);

      // all four held and re-requesting: expect 0,1,2,3,0
      rs = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 2'b00);
      for (int r = 0; r < 5; r++) begin
         mid_add = 4'b0001 << ((m_last + 1) % N);
         tx_dly = 1; tx_len = 3;
         serve(1'b0);
      end
      req = '0;
      rs  = 1'b1;

      // rate change on requester 2
      set_req(2, 8'h3C, 2'b11);
      tx_dly = 2; tx_len = 5;
      serve(1'b0);

      // requester 1 withdraws while 3 holds
      set_req(0, 8'h55, 2'b11);
      mid_add  = 4'b1010;
      end_drop = 4'b0010;
      serve(1'b0);
      chk("skip_pending", 32'(req), 32'(4'b1000));
      serve(1'b0);

      // reset during WAIT_DONE
      req = '0;
      set_req(0, 8'h77, 2'b01);
      tx_dly = 0;
      serve(1'b1);
      req = '0;
      m_last = N - 1;
      m_rate = 2'b00;
      @(negedge clk) reset = 1'b0;
      step();
      chk("rst_n_rerelease", 32'(baud_rst_n), 1);
      set_req(0, 8'h77, 2'b00);
      tx_dly = 1; tx_len = 2;
      serve(1'b0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
      begin
         int c, lows;
         set_req(1, 8'h99, m_rate);
         step();
         chk("to_grant", 32'(grant), 32'(4'b0010));
         m_last = 1;
         req    = '0;
         step();
         chk("to_start", 32'(tx_start), 1);
         c = 0;
         while (timeout_err !== 1'b1 && c < 2 * TIMEOUT) begin
            step();
            c++;
         end
         chk("to_cycles", 32'(c), 32'(TIMEOUT));
         lows = 0;
         while (baud_rst_n == 1'b0 && lows < 3 * SETTLE) begin
            lows++;
            step();
            if (lows == 1) chk("to_pulse", 32'(timeout_err), 0);
         end
         chk("to_rst_low", 32'(lows), 32'(SETTLE));
         chk("to_idle", 32'(busy), 0);
      end
`endif

      // randomized traffic
      for (int r = 0; r < 40; r++) begin
         if (req == '0) new_req(int'($urandom_range(0, N - 1)));
         mid_add  = 4'($urandom);
         end_drop = ($urandom_range(0, 3) == 0) ? 4'b0001 << $urandom_range(0, N - 1) : 4'b0000;
         tx_dly   = int'($urandom_range(0, 3));
         tx_len   = int'($urandom_range(1, 12));
         if (req == '0) new_req(0);
         serve(1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
